// File: rtl/ro_puf_resp_ctrl_pkg.sv
// rtl/ro_puf_resp_ctrl_pkg.sv - shared types, defaults and helpers for the RO-PUF response controller
//
// Purpose : state encoding, default geometry/timing constants and a clog2
//           helper shared by the controller, its window timer and its interface.
// Ports   : none (package).
package ro_puf_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    RUN    = 3'd2,
    SETTLE = 3'd3,
    SAMPLE = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DEF_N_CHAL        = 4;
  localparam int DEF_SW            = 2;
  localparam int DEF_CW            = 4;
  localparam int DEF_WIN_CYCLES    = 16;
  localparam int DEF_SETTLE_CYCLES = 2;

  // Minimum bit count able to index 'value' distinct items (returns 1 for value <= 2).
  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) res++;
    return (res == 0) ? 1 : res;
  endfunction

endpackage

// File: rtl/ro_puf_resp_ctrl_if.sv
// rtl/ro_puf_resp_ctrl_if.sv - core-side and response-side signal bundle of the RO-PUF controller
//
// Purpose : groups the oscillator-core control/count signals and the response
//           valid/ready channel.
// Signals : ro_en, ro_sel, ro_clr  controller -> core
//           count1, count2         core -> controller
//           resp_valid, resp, tie_mask, sat_mask  controller -> consumer
//           resp_ready             consumer -> controller
// Modports: master = controller view, slave = core/consumer view.
interface ro_puf_resp_ctrl_if
  import ro_puf_pkg::*;
#(
  parameter int N_CHAL = DEF_N_CHAL,
  parameter int SW     = DEF_SW,
  parameter int CW     = DEF_CW
);

  logic              ro_en;
  logic [SW-1:0]     ro_sel;
  logic              ro_clr;
  logic [CW-1:0]     count1;
  logic [CW-1:0]     count2;
  logic              resp_valid;
  logic              resp_ready;
  logic [N_CHAL-1:0] resp;
  logic [N_CHAL-1:0] tie_mask;
  logic [N_CHAL-1:0] sat_mask;

  modport master (
    output ro_en, ro_sel, ro_clr,
    input  count1, count2,
    output resp_valid, resp, tie_mask, sat_mask,
    input  resp_ready
  );

  modport slave (
    input  ro_en, ro_sel, ro_clr,
    output count1, count2,
    input  resp_valid, resp, tie_mask, sat_mask,
    output resp_ready
  );

endinterface

// File: rtl/ro_puf_resp_ctrl_win_timer.sv
// rtl/ro_puf_resp_ctrl_win_timer.sv - loadable down-counter timing the RUN and SETTLE intervals
//
// Purpose : counts down from a loaded value to zero and then holds; done is
//           high whenever the count is zero.  Loading N-1 therefore makes the
//           consuming state last exactly N cycles.
// Ports   : clk, reset (async, active-low), load, load_val [TW], done.
module ro_puf_win_timer #(
  parameter int TW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          done
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ro_puf_resp_ctrl.sv
// rtl/ro_puf_resp_ctrl.sv - sweeps RO-PUF challenge pairs and assembles the response word
//
// Purpose : for each challenge idx: clear the core counters (1 cycle), enable
//           the oscillators for WIN_CYCLES, wait SETTLE_CYCLES for the counts to
//           freeze, then compare count1/count2 and record resp/tie/sat bits.
//           After the last challenge the result is offered on a valid/ready
//           channel and held until accepted.
// Ports   : clk, reset (async, active-low)
//           start  one-cycle sweep request (IDLE only)
//           abort  synchronous return to IDLE, discards partial results
//           busy   high outside IDLE
//           bus    ro_puf_resp_ctrl_if.master (core control, counts, response)
module ro_puf_resp_ctrl
  import ro_puf_pkg::*;
#(
  parameter int N_CHAL        = DEF_N_CHAL,
  parameter int SW            = DEF_SW,
  parameter int CW            = DEF_CW,
  parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic                    busy,
  ro_puf_resp_ctrl_if.master      bus
);

  // Wide enough for WIN_CYCLES-1 and SETTLE_CYCLES-1.
  localparam int TW = clog2(WIN_CYCLES + SETTLE_CYCLES) + 1;

  state_t            state;
  logic [SW-1:0]     idx;
  logic              ro_en_q;
  logic              ro_clr_q;
  logic              busy_q;
  logic              valid_q;
  logic [N_CHAL-1:0] resp_q;
  logic [N_CHAL-1:0] tie_q;
  logic [N_CHAL-1:0] sat_q;

  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_done;

  logic              gt;
  logic              eq;
  logic              sat;

  // The timer is armed on the edge that enters RUN (from CLEAR) and on the
  // edge that enters SETTLE (end of RUN), so each interval starts fresh.
  assign tmr_load = (state == CLEAR) || ((state == RUN) && tmr_done);
  assign tmr_val  = (state == CLEAR) ? TW'(WIN_CYCLES - 1) : TW'(SETTLE_CYCLES - 1);

  ro_puf_win_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Counts are frozen during SAMPLE, so the compare can be purely combinational.
  assign gt  = (bus.count1 > bus.count2);
  assign eq  = (bus.count1 == bus.count2);
  assign sat = (bus.count1 == {CW{1'b1}}) || (bus.count2 == {CW{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      ro_en_q  <= 1'b0;
      ro_clr_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resp_q   <= '0;
      tie_q    <= '0;
      sat_q    <= '0;
    end else if (abort) begin
      // Abort overrides every other request, including start and resp_ready.
      state    <= IDLE;
      idx      <= '0;
      ro_en_q  <= 1'b0;
      ro_clr_q <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      resp_q   <= '0;
      tie_q    <= '0;
      sat_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state    <= CLEAR;
            idx      <= '0;
            ro_clr_q <= 1'b1;
            busy_q   <= 1'b1;
            resp_q   <= '0;
            tie_q    <= '0;
            sat_q    <= '0;
          end
        end
        CLEAR: begin
          state    <= RUN;
          ro_clr_q <= 1'b0;
          ro_en_q  <= 1'b1;
        end
        RUN: begin
          if (tmr_done) begin
            state   <= SETTLE;
            ro_en_q <= 1'b0;
          end
        end
        SETTLE: begin
          if (tmr_done) state <= SAMPLE;
        end
        SAMPLE: begin
          resp_q[idx] <= gt;
          tie_q[idx]  <= eq;
          sat_q[idx]  <= sat;
          if (idx == SW'(N_CHAL - 1)) begin
            state   <= DONE;
            valid_q <= 1'b1;
          end else begin
            // ro_sel moves only here, while the oscillators are stopped.
            idx      <= idx + SW'(1);
            state    <= CLEAR;
            ro_clr_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          idx      <= '0;
          ro_en_q  <= 1'b0;
          ro_clr_q <= 1'b0;
          busy_q   <= 1'b0;
          valid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ro_en      = ro_en_q;
  assign bus.ro_clr     = ro_clr_q;
  assign bus.ro_sel     = idx;
  assign bus.resp_valid = valid_q;
  assign bus.resp       = resp_q;
  assign bus.tie_mask   = tie_q;
  assign bus.sat_mask   = sat_q;
  assign busy           = busy_q;

endmodule

// File: doc/ro_puf_resp_ctrl.md
Name: ro_puf_resp_ctrl

Overview:
Controller that sits directly in front of the ring-oscillator PUF core and consumes its counter outputs. It drives the core's enable, challenge select and counter clear. It sweeps all challenge pairs with timed measurement windows, compares the two per-pair counts and assembles an N-bit PUF response. The response is delivered with tie and saturation flags over a valid/ready handshake.

Parameters:
N_CHAL, 4, number of challenge pairs swept; also the response width.
SW, 2, challenge-select width; must equal clog2(N_CHAL).
CW, 4, width of count1/count2 from the core.
WIN_CYCLES, 16, clk cycles ro_en is held high per challenge (>=1).
SETTLE_CYCLES, 2, clk cycles after ro_en falls before counts are sampled (>=1).

Ports:
clk  input  1  system clock; all state on rising edge.
reset  input  1  asynchronous, active-low reset.
start  input  1  one-cycle request to start a full sweep; honoured only in IDLE.
abort  input  1  synchronous abort; returns to IDLE from any state.
count1  input  CW  counter value of the mux-A oscillator.
count2  input  CW  counter value of the mux-B oscillator.
ro_en  output  1  oscillator enable to the core.
ro_sel  output  SW  challenge select S to the core.
ro_clr  output  1  active-high counter clear to the core.
busy  output  1  high in every state except IDLE.
resp_valid  output  1  response available.
resp_ready  input  1  consumer accepts the response.
resp  output  N_CHAL  bit i = (count1 > count2) for challenge i.
tie_mask  output  N_CHAL  bit i = (count1 == count2) for challenge i.
sat_mask  output  N_CHAL  bit i = either count equal to all-ones at sample (possible wrap).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, idx=0, all timers 0. Outputs ro_en=0, ro_sel=0, ro_clr=0, busy=0, resp_valid=0, resp=0, tie_mask=0, sat_mask=0.
- IDLE: start=1 -> CLEAR, idx=0. Also clears resp, tie_mask and sat_mask to 0.
- CLEAR (1 cycle): ro_clr=1, ro_en=0 -> RUN.
- RUN (WIN_CYCLES cycles): ro_en=1, ro_clr=0 -> SETTLE.
- SETTLE (SETTLE_CYCLES cycles): ro_en=0, so the oscillators stop and the counts freeze -> SAMPLE.
- SAMPLE (1 cycle): register resp[idx], tie_mask[idx] and sat_mask[idx] from count1/count2 (unsigned compare).
  - If idx==N_CHAL-1 -> DONE.
  - Otherwise idx++ -> CLEAR.
- DONE: resp_valid=1. resp, tie_mask and sat_mask are held stable while resp_valid=1. resp_valid & resp_ready at an edge -> IDLE; resp_valid is 0 the next cycle.
- ro_sel = idx; it changes only on the SAMPLE->CLEAR edge, never while ro_en=1.
- ro_en and ro_clr are registered outputs (glitch-free) and are never both 1.
- Timing with defaults: each challenge takes 20 cycles (1+16+2+1). resp_valid first reads 1 in the cycle after the 80th rising edge following the edge that sampled start.
- Boundaries:
  - start outside IDLE: ignored.
  - start and abort in the same IDLE cycle: abort wins, stay IDLE.
  - abort in any state: -> IDLE at the next edge. ro_en=0 and resp_valid=0 from then on; partial resp is discarded (cleared).
  - abort in DONE with resp_ready=1: abort wins, no transfer.
  - resp_ready=1 outside DONE: no effect.
  - Counts equal: resp bit=0 and tie bit=1.
  - Count all-ones: sat bit=1; resp is still computed from the raw values.
  - Reset asserted mid-sweep: immediate return to reset values; the sweep is not resumed.

Decomposition:
- Shared package ro_puf_pkg holds:
  - state enum: IDLE, CLEAR, RUN, SETTLE, SAMPLE, DONE;
  - default N_CHAL, CW and timing constants;
  - a clog2 function.
- One natural sub-module, ro_puf_win_timer: loadable down-counter with a done flag, used for both the RUN and SETTLE intervals.
- Compare and sample logic stays in the top.

Test Plan:
- Basic sweep: model count1={9,3,7,5} and count2={4,8,7,15} for idx 0..3; pulse start. Required: resp_valid at edge 80, resp=4'b0001, tie_mask=4'b0100, sat_mask=4'b1000.
- Timing and protocol checks:
  - ro_en high exactly 16 cycles per challenge, 4 windows total.
  - ro_clr 1-cycle pulse before each window.
  - ro_sel steps 0,1,2,3 with no change while ro_en=1.
- Backpressure: hold resp_ready=0 for 10 cycles after valid. Required: resp, tie_mask and sat_mask stable, busy=1. Raise resp_ready: IDLE next cycle, resp_valid=0.
- Abort at cycle 30 (challenge 1 RUN): ro_en=0 at the next edge, busy=0, no resp_valid. A following start produces a full fresh 80-cycle sweep.
- Asynchronous reset pulse at cycle 45, between clock edges: all outputs 0 immediately. A start 2 cycles after reset is released gives a normal sweep.
- start pulses during RUN and DONE: ignored, no restart and idx unaffected. start and abort together in IDLE: stays IDLE.
